// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem word index and registers the
// returned word into IF/ID. Handles stall, redirect with flush, halt requests and bad-target faults.
// Latency: one edge from imem_addr to IF/ID; a redirect costs one bubble.
// Backpressure: stall freezes PC, IF/ID and fetch_count. A redirect overrides stall.
// Halt and fault freeze all state until reset.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   stall, redirect,             pipeline control from downstream
//   redirect_target, halt_req
//   imem_addr / imem_inst        word index out, combinational read data in
//   if_id_valid/inst/pc          IF/ID pipeline register
//   halted, fault                sticky status flags
//   fetch_count                  saturating count of valid instructions delivered
module fetch_unit #(
  parameter int ADDR_WIDTH  = 5,
  parameter int BASE_INDEX  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_target,
  input  logic                   halt_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [31:0]            imem_inst,
  output logic                   if_id_valid,
  output logic [31:0]            if_id_inst,
  output logic [31:0]            if_id_pc,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  localparam int MAX_IDX = (1 << ADDR_WIDTH) - 1;

  logic [ADDR_WIDTH-1:0] pc_idx;
  logic [30:0]           tgt_sum;
  logic                  tgt_legal;
  logic [ADDR_WIDTH-1:0] tgt_idx;
  logic [ADDR_WIDTH-1:0] rel_idx;
  logic [31:0]           pc_byte;

  // The target's word index is computed at full width, so that targets past the end
  // of the memory are caught rather than silently wrapped into range.
  assign tgt_sum   = {1'b0, redirect_target[31:2]} + 31'(BASE_INDEX);
  assign tgt_legal = (redirect_target[1:0] == 2'b00) && (tgt_sum <= 31'(MAX_IDX));
  assign tgt_idx   = tgt_sum[ADDR_WIDTH-1:0];

  // The byte PC of the word being fetched. Index 0 maps to a meaningless PC,
  // but that fetch is always a bubble.
  assign rel_idx = pc_idx - ADDR_WIDTH'(BASE_INDEX);
  assign pc_byte = {{(30-ADDR_WIDTH){1'b0}}, rel_idx, 2'b00};

  assign imem_addr = pc_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_idx      <= '0;
      if_id_valid <= 1'b0;
      if_id_inst  <= '0;
      if_id_pc    <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else if (halted) begin
      // Frozen until reset; a fault always sets halted, so this also covers fault.
    end else if (halt_req) begin
      halted      <= 1'b1;
      if_id_valid <= 1'b0;
    end else if (redirect && !tgt_legal) begin
      fault       <= 1'b1;
      halted      <= 1'b1;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      // The wrong-path flush: inst/pc keep stale contents under valid=0.
      pc_idx      <= tgt_idx;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc_idx      <= pc_idx + 1'b1;
      if_id_inst  <= imem_inst;
      if_id_pc    <= pc_byte;
      // Index 0 is never part of the program, so its fetch is a bubble.
      if_id_valid <= (pc_idx != '0);
      if ((pc_idx != '0) && (fetch_count != {COUNT_WIDTH{1'b1}}))
        fetch_count <= fetch_count + COUNT_WIDTH'(1);
    end
  end

endmodule
